seg7_scan_256: RTL

//  Multi-digit 7-segment scan driver; consumes the clk_256 square wave from the 256 Hz divider.

---
 rtl/seg7_scan_256.sv | 203 ++++++++++++++++++++
 1 files changed

// File: rtl/seg7_scan_256.sv
// seg7_scan_256: multiplexed 7-segment scan driver clocked by clk_20k.
// Steps one digit per rising edge of clk_256, inserts an all-anodes-off
// gap between digits, blanks leading zeros, and loads new values only at
// frame wrap to avoid tearing.
// Optional macro SEG7_DIM_EN adds a 4-bit 'bright' input for PWM dimming.
module seg7_scan_256 #(
    parameter int NUM_DIGITS = 4,
    parameter int GAP_CYC    = 2
) (
    input  logic                    clk_20k,
    input  logic                    rst,
    input  logic                    clk_256,
    input  logic [4*NUM_DIGITS-1:0] digits,
    input  logic [NUM_DIGITS-1:0]   dp_mask,
    input  logic                    blank_lz,
    input  logic                    load,
`ifdef SEG7_DIM_EN
    input  logic [3:0]              bright,
`endif
    output logic [NUM_DIGITS-1:0]   an,
    output logic [6:0]              seg,
    output logic                    dp,
    output logic                    frame_done
);
    localparam int               IDX_W    = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_DIGITS - 1);
    localparam logic [3:0]       GAP_INIT = 4'(GAP_CYC);

    typedef enum logic {ST_GAP, ST_SHOW} state_t;

    state_t                  state_q, state_d;
    logic [3:0]              gap_cnt_q, gap_cnt_d;
    logic [IDX_W-1:0]        idx_q, idx_d;
    logic                    clk_256_q, clk_256_d;
    logic [4*NUM_DIGITS-1:0] stage_dig_q, stage_dig_d;
    logic [NUM_DIGITS-1:0]   stage_dp_q, stage_dp_d;
    logic [4*NUM_DIGITS-1:0] shadow_dig_q, shadow_dig_d;
    logic [NUM_DIGITS-1:0]   shadow_dp_q, shadow_dp_d;
    logic                    pending_q, pending_d;
    logic [NUM_DIGITS-1:0]   an_q, an_d;
    logic [6:0]              seg_q, seg_d;
    logic                    dp_q, dp_d;
    logic                    frame_done_q, frame_done_d;
`ifdef SEG7_DIM_EN
    logic [3:0]              pwm_cnt_q, pwm_cnt_d;
`endif

    logic                    tick, wrap;
    logic [NUM_DIGITS-1:0]   zero_from;
    logic                    zero_run;
    logic [3:0]              cur_nib;
    logic                    cur_dpm, cur_zero, blanked, pwm_on;

    function automatic logic [6:0] hex_to_seg(input logic [3:0] h);
        logic [6:0] s;
        case (h)
            4'h0: s = 7'h40;  4'h1: s = 7'h79;  4'h2: s = 7'h24;  4'h3: s = 7'h30;
            4'h4: s = 7'h19;  4'h5: s = 7'h12;  4'h6: s = 7'h02;  4'h7: s = 7'h78;
            4'h8: s = 7'h00;  4'h9: s = 7'h10;  4'hA: s = 7'h08;  4'hB: s = 7'h03;
            4'hC: s = 7'h46;  4'hD: s = 7'h21;  4'hE: s = 7'h06;  default: s = 7'h0E;
        endcase
        return s;
    endfunction

    // Scan sequencing: edge detect, gap/show FSM, index advance, frame-aligned loading
    always_comb begin
        clk_256_d    = clk_256;
        tick         = clk_256 & ~clk_256_q;
        wrap         = tick && (idx_q == LAST_IDX);
        state_d      = state_q;
        gap_cnt_d    = gap_cnt_q;
        idx_d        = idx_q;
        stage_dig_d  = stage_dig_q;
        stage_dp_d   = stage_dp_q;
        shadow_dig_d = shadow_dig_q;
        shadow_dp_d  = shadow_dp_q;
        pending_d    = pending_q;
        frame_done_d = wrap;

        if (load) begin
            stage_dig_d = digits;
            stage_dp_d  = dp_mask;
            pending_d   = 1'b1;
        end
        if (wrap) begin
            if (load) begin
                shadow_dig_d = digits;
                shadow_dp_d  = dp_mask;
                pending_d    = 1'b0;
            end else if (pending_q) begin
                shadow_dig_d = stage_dig_q;
                shadow_dp_d  = stage_dp_q;
                pending_d    = 1'b0;
            end
        end

        // gap_cnt holds the blank cycles still owed including the current one,
        // so the gap lasts exactly GAP_CYC cycles (at least one when GAP_CYC=0)
        case (state_q)
            ST_GAP: begin
                if (gap_cnt_q <= 4'd1) begin
                    state_d   = ST_SHOW;
                    gap_cnt_d = '0;
                end else begin
                    gap_cnt_d = gap_cnt_q - 4'd1;
                end
            end
            ST_SHOW: ;
            default: state_d = ST_GAP;
        endcase

        if (tick) begin
            idx_d     = wrap ? '0 : idx_q + IDX_W'(1);
            state_d   = ST_GAP;
            gap_cnt_d = GAP_INIT;
        end
    end

`ifdef SEG7_DIM_EN
    assign pwm_cnt_d = pwm_cnt_q + 4'd1;
    assign pwm_on    = (pwm_cnt_d < bright);
`else
    assign pwm_on    = 1'b1;
`endif

    // Output decode from next-state values so the registered outputs line up with the state
    always_comb begin
        zero_from = '0;
        zero_run  = 1'b1;
        for (int unsigned k = 0; k < NUM_DIGITS; k++) begin
            zero_run = zero_run && (shadow_dig_d[4*(NUM_DIGITS-1-k) +: 4] == 4'h0);
            zero_from[NUM_DIGITS-1-k] = zero_run;
        end
        cur_nib  = '0;
        cur_dpm  = 1'b0;
        cur_zero = 1'b0;
        for (int unsigned k = 0; k < NUM_DIGITS; k++) begin
            if (idx_d == IDX_W'(k)) begin
                cur_nib  = shadow_dig_d[4*k +: 4];
                cur_dpm  = shadow_dp_d[k];
                cur_zero = zero_from[k];
            end
        end
        blanked = blank_lz && cur_zero && (idx_d != '0);

        an_d  = '1;
        seg_d = 7'h7F;
        dp_d  = 1'b1;
        if ((state_d == ST_SHOW) && !blanked) begin
            seg_d = hex_to_seg(cur_nib);
            dp_d  = ~cur_dpm;
            for (int unsigned k = 0; k < NUM_DIGITS; k++) begin
                if ((idx_d == IDX_W'(k)) && pwm_on) an_d[k] = 1'b0;
            end
        end
    end

    // State and output registers with synchronous reset
    always_ff @(posedge clk_20k) begin
        if (rst) begin
            state_q      <= ST_GAP;
            gap_cnt_q    <= GAP_INIT;
            idx_q        <= '0;
            clk_256_q    <= 1'b0;
            stage_dig_q  <= '0;
            stage_dp_q   <= '0;
            shadow_dig_q <= '0;
            shadow_dp_q  <= '0;
            pending_q    <= 1'b0;
            an_q         <= '1;
            seg_q        <= 7'h7F;
            dp_q         <= 1'b1;
            frame_done_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            gap_cnt_q    <= gap_cnt_d;
            idx_q        <= idx_d;
            clk_256_q    <= clk_256_d;
            stage_dig_q  <= stage_dig_d;
            stage_dp_q   <= stage_dp_d;
            shadow_dig_q <= shadow_dig_d;
            shadow_dp_q  <= shadow_dp_d;
            pending_q    <= pending_d;
            an_q         <= an_d;
            seg_q        <= seg_d;
            dp_q         <= dp_d;
            frame_done_q <= frame_done_d;
        end
    end

`ifdef SEG7_DIM_EN
    // Free-running dimming counter
    always_ff @(posedge clk_20k) begin
        if (rst) pwm_cnt_q <= '0;
        else     pwm_cnt_q <= pwm_cnt_d;
    end
`endif

    assign an         = an_q;
    assign seg        = seg_q;
    assign dp         = dp_q;
    assign frame_done = frame_done_q;
endmodule
